// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Stack sequencer state encoding and stack-page parameters.
package cpu_pkg;

  localparam logic [7:0] STACK_PAGE = 8'h01;

  localparam logic [1:0] PUSH_PC  = 2'd2;
  localparam logic [1:0] PUSH_INT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_PULL_INC,
    ST_PULL_RD,
    ST_PULL_LAST,
    ST_DONE
  } stack_state_t;

endpackage

// File: rtl/stack_byte_asm.sv
// Pull-data assembler: collects read bytes into slots.
// Result register updates only when a pull completes.
module stack_byte_asm
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BYTES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [1:0]                 idx,
  input  logic [WIDTH-1:0]           rdata,
  input  logic                       commit,
  output logic [MAX_BYTES*WIDTH-1:0] pull_data
);

  logic [MAX_BYTES*WIDTH-1:0] acc;
  logic [MAX_BYTES*WIDTH-1:0] acc_nxt;

  // Merge the incoming byte into its slot.
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (wr_en && (int'(idx) == i)) begin
        acc_nxt[i*WIDTH +: WIDTH] = rdata;
      end
    end
  end

  // Accumulator cleared at pull start; result held until commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      pull_data <= '0;
    end else begin
      if (clr) begin
        acc <= '0;
      end else begin
        acc <= acc_nxt;
      end
      if (commit) begin
        pull_data <= acc_nxt;
      end
    end
  end

endmodule

// File: rtl/stack_seq.sv
// Stack access sequencer for page-1 push/pull transfers.
// Push writes then decrements; pull increments then reads.
module stack_seq
  import cpu_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] STACK_PAGE = cpu_pkg::STACK_PAGE,
  parameter int               MAX_BYTES  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_pull,
  input  logic [1:0]                 req_count,
  input  logic [MAX_BYTES*WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0]           sp,
  output logic                       sp_inc,
  output logic                       sp_dec,
  output logic [2*WIDTH-1:0]         mem_addr,
  output logic                       mem_we,
  output logic                       mem_re,
  output logic [WIDTH-1:0]           mem_wdata,
  input  logic [WIDTH-1:0]           mem_rdata,
  output logic [MAX_BYTES*WIDTH-1:0] pull_data,
  output logic                       done
);

  stack_state_t state;
  stack_state_t state_nxt;

  logic [1:0]                 cnt;
  logic [1:0]                 idx;
  logic [MAX_BYTES*WIDTH-1:0] pdata;
  logic                       accept;
  logic [WIDTH-1:0]           wbyte;
  logic                       asm_wr;
  logic                       asm_commit;
  logic [1:0]                 asm_idx;

  assign accept = req_valid && req_ready;

  // Most significant remaining push byte.
  always_comb begin
    wbyte = '0;
    for (int k = 1; k <= MAX_BYTES; k++) begin
      if (int'(cnt) == k) begin
        wbyte = pdata[k*WIDTH-1 -: WIDTH];
      end
    end
  end

  // Strobes and address decode straight from state and sp.
  always_comb begin
    sp_dec    = (state == ST_PUSH);
    mem_we    = (state == ST_PUSH);
    sp_inc    = (state == ST_PULL_INC);
    mem_re    = (state == ST_PULL_RD);
    mem_addr  = {STACK_PAGE, sp};
    mem_wdata = (state == ST_PUSH) ? wbyte : '0;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_count == 2'd0) state_nxt = ST_DONE;
          else if (req_pull)     state_nxt = ST_PULL_INC;
          else                   state_nxt = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (cnt == 2'd1) state_nxt = ST_DONE;
      end
      ST_PULL_INC: state_nxt = ST_PULL_RD;
      ST_PULL_RD: begin
        if (cnt > 2'd1) state_nxt = ST_PULL_INC;
        else            state_nxt = ST_PULL_LAST;
      end
      ST_PULL_LAST: state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      pdata     <= '0;
      req_ready <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == ST_IDLE);
      done      <= (state_nxt == ST_DONE);
      if (accept) begin
        cnt   <= req_count;
        idx   <= '0;
        pdata <= push_data;
      end else if (state == ST_PUSH) begin
        cnt <= cnt - 2'd1;
      end else if (state == ST_PULL_RD) begin
        cnt <= cnt - 2'd1;
        idx <= idx + 2'd1;
      end
    end
  end

  assign asm_wr = ((state == ST_PULL_INC) && (idx != 2'd0))
                || (state == ST_PULL_LAST);
  assign asm_commit = (state == ST_PULL_LAST);
  assign asm_idx    = idx - 2'd1;

  stack_byte_asm #(
    .WIDTH     (WIDTH),
    .MAX_BYTES (MAX_BYTES)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept && req_pull),
    .wr_en     (asm_wr),
    .idx       (asm_idx),
    .rdata     (mem_rdata),
    .commit    (asm_commit),
    .pull_data (pull_data)
  );

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Stack access sequencer between the instruction control logic and the stack pointer register.
- Accepts push/pull requests of 1–3 bytes (PHA/PHP, JSR, BRK/IRQ, PLA/PLP, RTS, RTI).
- Issues page-1 memory accesses at {STACK_PAGE, sp}.
- Drives the stack pointer's sp_inc/sp_dec strobes with 6502 ordering: push writes then decrements; pull increments then reads.

Parameters:
- WIDTH, 8, stack pointer and data byte width.
- STACK_PAGE, 8'h01, high address byte of the stack page.
- MAX_BYTES, 3, maximum bytes per request; also sets the data bus widths (MAX_BYTES*WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request strobe.
- req_ready  out  1  high when idle and able to accept a request.
- req_pull  in  1  0 = push, 1 = pull.
- req_count  in  2  number of bytes, 0..3.
- push_data  in  24  bytes to push, right-justified.
- sp  in  8  current stack pointer value.
- sp_inc  out  1  increment strobe to the stack pointer.
- sp_dec  out  1  decrement strobe to the stack pointer.
- mem_addr  out  16  stack memory address.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data, valid the cycle after mem_re.
- pull_data  out  24  assembled pull result, zero-extended.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; count and byte registers clear; pull_data=0.
  - sp_inc, sp_dec, mem_we, mem_re and done are 0; mem_addr={STACK_PAGE,sp}; mem_wdata=0.
  - req_ready is 1 in IDLE, including while rst is held.
  - Reset mid-operation abandons the transfer with no done pulse. The stack pointer register is reset separately.
- Handshake:
  - A request is accepted on a clock edge with req_valid && req_ready.
  - req_pull, req_count and push_data are latched at acceptance.
  - req_ready=0 whenever the state is not IDLE. req_valid while busy is ignored and not queued.
- States: IDLE, PUSH, PULL_INC, PULL_RD, PULL_LAST, DONE.
- IDLE:
  - Accept with count 0 → DONE, with no memory or stack pointer activity.
  - Accept push → PUSH.
  - Accept pull → PULL_INC.
- PUSH (one cycle per byte):
  - mem_addr={STACK_PAGE,sp}, mem_we=1, sp_dec=1.
  - mem_wdata is the most significant remaining byte: push_data[8*k-1 -: 8], where k = bytes remaining.
  - Ordering example: count 3 = PCH, PCL, P.
  - After the last byte → DONE. A push of N bytes takes N cycles plus DONE.
- PULL_INC:
  - sp_inc=1.
  - If a previous read is outstanding, capture mem_rdata into byte slot (index-1).
  - → PULL_RD.
- PULL_RD:
  - mem_re=1, mem_addr={STACK_PAGE,sp}, using the already-incremented sp.
  - If more bytes remain → PULL_INC; otherwise → PULL_LAST.
- PULL_LAST:
  - Capture the final mem_rdata → DONE.
- Pull byte placement:
  - The first pulled byte goes to pull_data[7:0], the second to [15:8], the third to [23:16].
  - Unused upper bytes are 0.
  - A pull of N bytes takes 2N+1 cycles plus DONE.
- DONE:
  - done=1 for one cycle → IDLE.
  - pull_data holds its value until the next pull completes or reset. A push leaves pull_data unchanged.
- Strobe exclusivity: sp_inc and sp_dec are never asserted in the same cycle. mem_we and mem_re are never asserted in the same cycle.
- Wrap-around:
  - sp wraps 0x00↔0xFF silently; no overflow or underflow flag.
  - mem_addr high byte is always STACK_PAGE.
- Only mem_wdata, mem_addr and the strobes are combinational from state and sp. All other outputs are registered.

Decomposition:
- Shared package cpu_pkg:
  - stack state enum stack_state_t.
  - STACK_PAGE constant.
  - byte-count constants PUSH_PC=2, PUSH_INT=3.
- One sub-module: stack_byte_asm. It is the pull-data assembler (byte-slot write enable, index, zero-extend, clear on reset).
- The FSM and push byte mux stay in stack_seq.

Test Plan:
- Push 1 (PHA): sp=0xFD, push_data=0x0000A5 → one cycle with mem_we, addr 0x01FD, wdata 0xA5, sp_dec. done the cycle after. sp becomes 0xFC.
- Push 3 (BRK): sp=0xFF, push_data=0x12_34_B0 → writes 0x01FF=0x12, 0x01FE=0x34, 0x01FD=0xB0 on consecutive cycles. sp_dec ×3, final sp 0xFC, then done.
- Pull 2 (RTS): sp=0xFA, memory 0x01FB=0x78, 0x01FC=0x56 → alternating sp_inc/mem_re, reads at 0x01FB then 0x01FC. pull_data=0x005678, done after 6 cycles.
- Wrap: sp=0x00, push 2 → addresses 0x0100, then 0x01FF; final sp 0xFE. Pull 1 from sp=0xFF → read 0x0100.
- Busy and count 0: req_valid held during a 3-byte push → second request not accepted until req_ready returns. count 0 → done next cycle, no strobes.
- Reset mid-pull: assert rst during PULL_RD → all strobes 0 immediately, req_ready=1, pull_data=0, no done pulse.
